video_timing_meter: RTL
=======================

// Module: video_timing_meter
// PURPOSE
//   Receive-side counterpart of the core's video timing generator: samples the pixel-rate
//   sync/blank stream (CE_PIXEL, HS, VS, HBlank, VBlank) and measures per-frame timing.
//   Reports total/active line length, total/active line count and a frame counter.
//   Flags when the timing is stable. Sits on CLK_VIDEO beside the video output, feeding OSD/debug.
// PARAMETERS
//   CNT_W        12  width of pixel and line counters; counters saturate at 2**CNT_W-1
//   FRAME_W      16  width of frame_cnt (wraps)
//   LOCK_FRAMES   2  consecutive identical frames required before meas_valid rises (>=1)
// PORTS
//   clk        in   1        video clock (CLK_VIDEO)
//   reset_n    in   1        synchronous reset, active low
//   ce_pix     in   1        pixel enable; all inputs below are sampled only when ce_pix=1
//   hsync      in   1        horizontal sync, active high
//   vsync      in   1        vertical sync, active high
//   hblank     in   1        horizontal blank
//   vblank     in   1        vertical blank
//   h_total    out  CNT_W    pixels per line (ce_pix count between hsync rising edges)
//   h_active   out  CNT_W    pixels with hblank=0 in that line
//   v_total    out  CNT_W    lines per frame (hsync rising edges between vsync rising edges)
//   v_active   out  CNT_W    lines per frame containing >=1 pixel with hblank=0 and vblank=0
//   frame_cnt  out  FRAME_W  completed measured frames
//   meas_stb   out  1        one-clk pulse when outputs update
//   meas_valid out  1        timing stable for LOCK_FRAMES frames, no overflow
//   overflow   out  1        last published frame saturated a counter
// BEHAVIOUR
//   - Reset (reset_n=0 at clk edge): every output 0; all counters, edge regs, armed flags cleared.
//   - Edge detect: the rising edge is a ce_pix sample with signal=1 and previous ce_pix sample=0.
//     Input changes between ce_pix samples are invisible. The previous-sample regs reset to 0.
//   - Pixel counter pix_cnt, on each ce: 0 on hsync rise, else +1 (saturating); act_cnt likewise
//     counts hblank=0 samples; line_act flag sets on hblank=0 & vblank=0.
//   - Line close (hsync rise): line_len = pix_cnt+1, line_actw = act_cnt (+1 if this sample has
//     hblank=0), both saturating. Then line_cnt+=1 and act_lines+=line_act. Both counters saturate.
//     The line in progress at vsync rise counts toward the ending frame only if its hsync rise
//     is in the same sample.
//   - Arming: the first hsync rise after reset only arms line measurement (no line closed).
//     The first vsync rise after reset only arms frame measurement: clears line_cnt and
//     act_lines; no publish.
//   - Simultaneous hsync+vsync rise in one sample: line close first (counted in ending frame),
//     then frame close; new frame starts line_cnt=0.
//   - Frame close (vsync rise, armed): publish on the next clk edge. h_total/h_active = last
//     closed line's values; v_total=line_cnt; v_active=act_lines. frame_cnt+=1 (wraps);
//     meas_stb=1 for exactly that clk. Latency: outputs valid 1 clk after the capturing ce cycle.
//   - overflow: set at publish if any counter saturated during that frame, else cleared.
//   - Stability: match_cnt (saturating at LOCK_FRAMES) increments on publish when all four
//     values equal the previously published set and overflow=0; else reset to 0. The first
//     published frame counts as 0.
//   - meas_valid = (match_cnt >= LOCK_FRAMES). It drops on the same clk as a mismatching
//     or overflowed publish.
//   - No ce_pix: nothing changes; outputs hold indefinitely.
// TESTING
//   1 NTSC-like 858x525, hblank=0 for 720 px, vblank=0 for 480 lines, ce_pix every 4 clk ->
//     3rd vsync rise: h_total=858 h_active=720 v_total=525 v_active=480 frame_cnt=2 valid=0;
//     4th: valid=1.
//   2 Switch the stream to 864x625 (PAL) while valid=1 -> first publish on the new timing has
//     v_total=625, meas_valid=0. Valid returns after LOCK_FRAMES further identical frames.
//   3 Toggle hsync while ce_pix=0 for 3 clks -> no line closed, h_total unchanged.
//   4 CNT_W=12, hsync held low 5000 ce inside a frame -> publish with overflow=1, h_total=4095,
//     meas_valid=0. Next clean frame: overflow=0.
//   5 hsync and vsync rise on same ce -> that line is counted in the ending frame's v_total;
//     next frame's v_total is unaffected.
//   6 Assert reset_n=0 mid-frame for 1 clk -> all outputs 0. The first vsync after reset does
//     not publish; the second publishes.

Source files
------------

// File: rtl/video_timing_meter.sv
// video_timing_meter: measures line and frame timing of a pixel-rate sync/blank
// stream and publishes per-frame totals, active sizes, a frame count and a lock flag.
module video_timing_meter #(
    parameter int unsigned CNT_W       = 12,
    parameter int unsigned FRAME_W     = 16,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ce_pix,
    input  logic               hsync,
    input  logic               vsync,
    input  logic               hblank,
    input  logic               vblank,
    output logic [CNT_W-1:0]   h_total,
    output logic [CNT_W-1:0]   h_active,
    output logic [CNT_W-1:0]   v_total,
    output logic [CNT_W-1:0]   v_active,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               meas_stb,
    output logic               meas_valid,
    output logic               overflow
);
    localparam int unsigned   MW     = $clog2(LOCK_FRAMES + 1);
    localparam logic [MW-1:0] LOCK_M = MW'(LOCK_FRAMES);

    logic               hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic               h_armed_q, h_armed_d, v_armed_q, v_armed_d;
    logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d, act_cnt_q, act_cnt_d;
    logic               line_act_q, line_act_d;
    logic [CNT_W-1:0]   line_len_q, line_len_d, line_actw_q, line_actw_d;
    logic [CNT_W-1:0]   line_cnt_q, line_cnt_d, act_lines_q, act_lines_d;
    logic               frame_ovf_q, frame_ovf_d;
    logic [CNT_W-1:0]   h_total_q, h_total_d, h_active_q, h_active_d;
    logic [CNT_W-1:0]   v_total_q, v_total_d, v_active_q, v_active_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               meas_stb_q, meas_stb_d, overflow_q, overflow_d;
    logic [MW-1:0]      match_q, match_d;
    logic               have_pub_q, have_pub_d;

    logic               hs_rise, vs_rise, act_px, sat_hit, ovf_now, same;
    logic [CNT_W-1:0]   close_len, close_actw, close_lines, close_alines;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Next-state: per-sample line counting, line close on hsync rise, frame close/publish on vsync rise.
    always_comb begin
        hs_prev_d    = hs_prev_q;
        vs_prev_d    = vs_prev_q;
        h_armed_d    = h_armed_q;
        v_armed_d    = v_armed_q;
        pix_cnt_d    = pix_cnt_q;
        act_cnt_d    = act_cnt_q;
        line_act_d   = line_act_q;
        line_len_d   = line_len_q;
        line_actw_d  = line_actw_q;
        line_cnt_d   = line_cnt_q;
        act_lines_d  = act_lines_q;
        frame_ovf_d  = frame_ovf_q;
        h_total_d    = h_total_q;
        h_active_d   = h_active_q;
        v_total_d    = v_total_q;
        v_active_d   = v_active_q;
        frame_cnt_d  = frame_cnt_q;
        meas_stb_d   = 1'b0;
        overflow_d   = overflow_q;
        match_d      = match_q;
        have_pub_d   = have_pub_q;
        hs_rise      = ce_pix & hsync & ~hs_prev_q;
        vs_rise      = ce_pix & vsync & ~vs_prev_q;
        act_px       = ~hblank & ~vblank;
        sat_hit      = 1'b0;
        close_len    = line_len_q;
        close_actw   = line_actw_q;
        close_lines  = line_cnt_q;
        close_alines = act_lines_q;
        ovf_now      = frame_ovf_q;
        same         = 1'b0;
        if (ce_pix) begin
            hs_prev_d = hsync;
            vs_prev_d = vsync;
            if (hs_rise) begin
                h_armed_d  = 1'b1;
                pix_cnt_d  = '0;
                act_cnt_d  = '0;
                line_act_d = 1'b0;
                if (h_armed_q) begin
                    // The rising-edge sample is the last pixel of the line it closes.
                    close_len    = sat_inc(pix_cnt_q);
                    close_actw   = hblank ? act_cnt_q : sat_inc(act_cnt_q);
                    close_lines  = sat_inc(line_cnt_q);
                    close_alines = (line_act_q | act_px) ? sat_inc(act_lines_q) : act_lines_q;
                    sat_hit      = (pix_cnt_q == '1) | (~hblank & (act_cnt_q == '1))
                                 | (line_cnt_q == '1) | ((line_act_q | act_px) & (act_lines_q == '1));
                end
            end else begin
                pix_cnt_d  = sat_inc(pix_cnt_q);
                act_cnt_d  = hblank ? act_cnt_q : sat_inc(act_cnt_q);
                line_act_d = line_act_q | act_px;
                sat_hit    = (pix_cnt_q == '1) | (~hblank & (act_cnt_q == '1));
            end
            line_len_d  = close_len;
            line_actw_d = close_actw;
            line_cnt_d  = close_lines;
            act_lines_d = close_alines;
            ovf_now     = frame_ovf_q | sat_hit;
            frame_ovf_d = ovf_now;
            if (vs_rise) begin
                if (v_armed_q) begin
                    // A line closed in this same sample is already folded into close_*.
                    same = have_pub_q & (close_len == h_total_q) & (close_actw == h_active_q)
                         & (close_lines == v_total_q) & (close_alines == v_active_q);
                    if (same & ~ovf_now)
                        match_d = (match_q >= LOCK_M) ? match_q : match_q + 1'b1;
                    else
                        match_d = '0;
                    h_total_d   = close_len;
                    h_active_d  = close_actw;
                    v_total_d   = close_lines;
                    v_active_d  = close_alines;
                    overflow_d  = ovf_now;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    meas_stb_d  = 1'b1;
                    have_pub_d  = 1'b1;
                end
                v_armed_d   = 1'b1;
                line_cnt_d  = '0;
                act_lines_d = '0;
                frame_ovf_d = 1'b0;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hs_prev_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            h_armed_q   <= 1'b0;
            v_armed_q   <= 1'b0;
            pix_cnt_q   <= '0;
            act_cnt_q   <= '0;
            line_act_q  <= 1'b0;
            line_len_q  <= '0;
            line_actw_q <= '0;
            line_cnt_q  <= '0;
            act_lines_q <= '0;
            frame_ovf_q <= 1'b0;
            h_total_q   <= '0;
            h_active_q  <= '0;
            v_total_q   <= '0;
            v_active_q  <= '0;
            frame_cnt_q <= '0;
            meas_stb_q  <= 1'b0;
            overflow_q  <= 1'b0;
            match_q     <= '0;
            have_pub_q  <= 1'b0;
        end else begin
            hs_prev_q   <= hs_prev_d;
            vs_prev_q   <= vs_prev_d;
            h_armed_q   <= h_armed_d;
            v_armed_q   <= v_armed_d;
            pix_cnt_q   <= pix_cnt_d;
            act_cnt_q   <= act_cnt_d;
            line_act_q  <= line_act_d;
            line_len_q  <= line_len_d;
            line_actw_q <= line_actw_d;
            line_cnt_q  <= line_cnt_d;
            act_lines_q <= act_lines_d;
            frame_ovf_q <= frame_ovf_d;
            h_total_q   <= h_total_d;
            h_active_q  <= h_active_d;
            v_total_q   <= v_total_d;
            v_active_q  <= v_active_d;
            frame_cnt_q <= frame_cnt_d;
            meas_stb_q  <= meas_stb_d;
            overflow_q  <= overflow_d;
            match_q     <= match_d;
            have_pub_q  <= have_pub_d;
        end
    end

    assign h_total    = h_total_q;
    assign h_active   = h_active_q;
    assign v_total    = v_total_q;
    assign v_active   = v_active_q;
    assign frame_cnt  = frame_cnt_q;
    assign meas_stb   = meas_stb_q;
    assign overflow   = overflow_q;
    assign meas_valid = (match_q >= LOCK_M);
endmodule
